// File: rtl/adder_result_buffer.sv
// Result FIFO behind a pipelined adder with credit-based issue control.
// Tracks in-flight operations so a well-behaved source can never overflow the buffer.
module adder_result_buffer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 8    // power of two, 2..64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           issue,
  input  logic                           o_en,
  input  logic [DATA_WIDTH:0]            result,
  output logic                           issue_ok,
  output logic                           m_valid,
  output logic [DATA_WIDTH:0]            m_data,
  input  logic                           m_ready,
  output logic [$clog2(DEPTH+1)-1:0]     level,
  output logic [$clog2(DEPTH+1)-1:0]     inflight,
  output logic                           err_ovf,
  output logic                           err_credit
);

  localparam int unsigned RW = DATA_WIDTH + 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [LW:0]   DEPTH_L1 = (LW+1)'(DEPTH);

  logic [RW-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] inflight_q, inflight_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_credit_q, err_credit_d;

  logic          pop_c;
  logic          full_c;
  logic          push_acc_c;
  logic [LW:0]   credit_used_c;
  logic          issue_ok_c;

  // Next-state logic for pointers, occupancy, credit tracking and sticky errors
  always_comb begin
    pop_c         = 1'b0;
    full_c        = 1'b0;
    push_acc_c    = 1'b0;
    credit_used_c = '0;
    issue_ok_c    = 1'b0;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    inflight_d    = inflight_q;
    err_ovf_d     = err_ovf_q;
    err_credit_d  = err_credit_q;

    pop_c      = (level_q != '0) & m_ready;
    full_c     = (level_q == DEPTH_L);
    // A full buffer still accepts when the head leaves in the same cycle
    push_acc_c = o_en & (~full_c | pop_c);

    credit_used_c = {1'b0, inflight_q} + {1'b0, level_q};
    issue_ok_c    = (credit_used_c < DEPTH_L1);

    if (push_acc_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_c)      rd_ptr_d = rd_ptr_q + PW'(1);
    level_d = level_q + LW'(push_acc_c) - LW'(pop_c);

    if (issue && !o_en && (inflight_q != DEPTH_L)) begin
      inflight_d = inflight_q + LW'(1);
    end else if (o_en && !issue && (inflight_q != '0)) begin
      inflight_d = inflight_q - LW'(1);
    end

    err_ovf_d    = err_ovf_q | (o_en & ~push_acc_c);
    err_credit_d = err_credit_q
                 | (issue & ~issue_ok_c)
                 | (o_en & ~issue & (inflight_q == '0));
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      inflight_q   <= '0;
      err_ovf_q    <= 1'b0;
      err_credit_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      inflight_q   <= inflight_d;
      err_ovf_q    <= err_ovf_d;
      err_credit_q <= err_credit_d;
    end
  end

  // Storage is not reset; only accepted results are written
  always_ff @(posedge clk) begin
    if (!rst && push_acc_c) begin
      mem_q[wr_ptr_q] <= result;
    end
  end

  assign issue_ok   = issue_ok_c;
  assign m_valid    = (level_q != '0);
  // Zero when empty so never-written storage cannot leak onto the bus
  assign m_data     = m_valid ? mem_q[rd_ptr_q] : '0;
  assign level      = level_q;
  assign inflight   = inflight_q;
  assign err_ovf    = err_ovf_q;
  assign err_credit = err_credit_q;

endmodule

// File: tb/tb_adder_result_buffer.sv
// Directed bench for adder_result_buffer (DATA_WIDTH=64, DEPTH=8): vector table
// followed by hand-written fill, full, overflow, wrap and reset sequences.
module tb_adder_result_buffer;

  logic        clk = 1'b0;
  logic        rst, issue, o_en, m_ready;
  logic [64:0] result;
  logic        issue_ok, m_valid, err_ovf, err_credit;
  logic [64:0] m_data;
  logic [3:0]  level, inflight;

  int tests = 0;
  int fails = 0;

  adder_result_buffer #(.DATA_WIDTH(64), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .issue(issue), .o_en(o_en), .result(result),
    .issue_ok(issue_ok), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .level(level), .inflight(inflight), .err_ovf(err_ovf), .err_credit(err_credit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, issue, o_en, m_ready;
    logic [64:0] result;
    logic        exp_mv;
    logic [64:0] exp_data;
    logic [3:0]  exp_level, exp_inf;
    logic        exp_ok, exp_ovf, exp_cr;
  } vec_t;

  function automatic vec_t mk(input logic r, i, e, rdy, input logic [64:0] res,
                              input logic mv, input logic [64:0] d,
                              input logic [3:0] lv, inf,
                              input logic ok, ovf, cr);
    vec_t v;
    v.rst = r; v.issue = i; v.o_en = e; v.m_ready = rdy; v.result = res;
    v.exp_mv = mv; v.exp_data = d; v.exp_level = lv; v.exp_inf = inf;
    v.exp_ok = ok; v.exp_ovf = ovf; v.exp_cr = cr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit after the rising edge
  task automatic step(input logic i_rst, i_issue, i_oen, input logic [64:0] i_res,
                      input logic i_rdy);
    @(negedge clk);
    rst = i_rst; issue = i_issue; o_en = i_oen; result = i_res; m_ready = i_rdy;
    @(posedge clk);
    #1;
  endtask

  localparam logic [64:0] R1 = 65'h1_0000_0000_0000_0001;
  localparam logic [64:0] R2 = 65'h0_FFFF_FFFF_FFFF_FFFF;
  localparam logic [64:0] R3 = 65'h1_8000_0000_0000_0000;
  localparam logic [64:0] R4 = 65'h0_1234_5678_9ABC_DEF0;

  vec_t vecs [14];
  logic [64:0] drain_exp [8];
  int n_issue, sent, recv;

  initial begin
    rst = 1'b1; issue = 1'b0; o_en = 1'b0; m_ready = 1'b0; result = '0;

    //              rst is oe rdy result  mv data lvl inf ok ovf cr
    vecs[0]  = mk(1, 0, 0, 0, '0, 0, '0, 0, 0, 1, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, '0, 0, '0, 0, 1, 1, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, '0, 0, '0, 0, 1, 1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, '0, 0, '0, 0, 1, 1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, '0, 0, '0, 0, 1, 1, 0, 0);
    vecs[5]  = mk(0, 0, 1, 1, R1, 1, R1, 1, 0, 1, 0, 0);
    vecs[6]  = mk(0, 0, 0, 1, '0, 0, '0, 0, 0, 1, 0, 0);
    vecs[7]  = mk(0, 1, 1, 0, R2, 1, R2, 1, 0, 1, 0, 0);
    vecs[8]  = mk(0, 1, 0, 1, '0, 0, '0, 0, 1, 1, 0, 0);
    vecs[9]  = mk(0, 0, 1, 0, R3, 1, R3, 1, 0, 1, 0, 0);
    vecs[10] = mk(0, 0, 1, 0, R4, 1, R3, 2, 0, 1, 0, 1);
    vecs[11] = mk(0, 0, 0, 1, '0, 1, R4, 1, 0, 1, 0, 1);
    vecs[12] = mk(1, 1, 1, 1, R1, 0, '0, 0, 0, 1, 0, 0);
    vecs[13] = mk(0, 1, 0, 0, '0, 0, '0, 0, 1, 1, 0, 0);

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].rst, vecs[i].issue, vecs[i].o_en, vecs[i].result, vecs[i].m_ready);
      chk($sformatf("v%0d_level", i),      65'(level),      65'(vecs[i].exp_level));
      chk($sformatf("v%0d_inflight", i),   65'(inflight),   65'(vecs[i].exp_inf));
      chk($sformatf("v%0d_m_valid", i),    65'(m_valid),    65'(vecs[i].exp_mv));
      chk($sformatf("v%0d_issue_ok", i),   65'(issue_ok),   65'(vecs[i].exp_ok));
      chk($sformatf("v%0d_err_ovf", i),    65'(err_ovf),    65'(vecs[i].exp_ovf));
      chk($sformatf("v%0d_err_credit", i), 65'(err_credit), 65'(vecs[i].exp_cr));
      if (vecs[i].exp_mv) chk($sformatf("v%0d_m_data", i), m_data, vecs[i].exp_data);
    end

    // Credit fill from a clean state
    step(1, 0, 0, '0, 0);
    n_issue = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      rst = 1'b0; o_en = 1'b0; m_ready = 1'b0;
      issue = issue_ok;
      if (issue_ok) n_issue++;
      @(posedge clk);
      #1;
    end
    chk("fill_issue_count", 65'(n_issue), 65'd8);
    chk("fill_issue_ok", 65'(issue_ok), 65'd0);
    chk("fill_inflight", 65'(inflight), 65'd8);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 65'(100 + i), 0);
    chk("fill_level", 65'(level), 65'd8);
    chk("fill_inflight_ret", 65'(inflight), 65'd0);
    chk("fill_issue_ok_full", 65'(issue_ok), 65'd0);
    chk("fill_err_ovf", 65'(err_ovf), 65'd0);
    chk("fill_err_credit", 65'(err_credit), 65'd0);
    chk("fill_head", m_data, 65'd100);

    // Full buffer with push and pop in the same cycle
    step(0, 0, 1, 65'd200, 1);
    chk("full_pp_level", 65'(level), 65'd8);
    chk("full_pp_head", m_data, 65'd101);
    chk("full_pp_err_ovf", 65'(err_ovf), 65'd0);

    // Overflow: full, no pop
    step(0, 0, 1, 65'd300, 0);
    chk("ovf_level", 65'(level), 65'd8);
    chk("ovf_err", 65'(err_ovf), 65'd1);
    chk("ovf_head", m_data, 65'd101);
    step(0, 0, 0, '0, 0);
    chk("ovf_sticky", 65'(err_ovf), 65'd1);

    for (int i = 0; i < 7; i++) drain_exp[i] = 65'(101 + i);
    drain_exp[7] = 65'd200;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_data", i), m_data, drain_exp[i]);
      step(0, 0, 0, '0, 1);
    end
    chk("drain_level", 65'(level), 65'd0);
    chk("drain_m_valid", 65'(m_valid), 65'd0);
    chk("drain_ovf_sticky", 65'(err_ovf), 65'd1);
    step(1, 0, 0, '0, 0);
    chk("rst_clr_ovf", 65'(err_ovf), 65'd0);
    chk("rst_clr_credit", 65'(err_credit), 65'd0);

    // Wrap: 20 values with random m_ready, issue and return in the same cycle
    sent = 0; recv = 0;
    for (int c = 0; c < 400 && recv < 20; c++) begin
      @(negedge clk);
      rst = 1'b0; issue = 1'b0; o_en = 1'b0; result = '0;
      m_ready = 1'($urandom_range(0, 1));
      if (sent < 20 && issue_ok && $urandom_range(0, 3) != 0) begin
        issue = 1'b1; o_en = 1'b1; result = 65'(sent); sent++;
      end
      #1;
      if (m_valid && m_ready) begin
        chk($sformatf("wrap_order%0d", recv), m_data, 65'(recv));
        recv++;
      end
    end
    step(0, 0, 0, '0, 0);
    chk("wrap_received", 65'(recv), 65'd20);
    chk("wrap_level", 65'(level), 65'd0);
    chk("wrap_err_ovf", 65'(err_ovf), 65'd0);
    chk("wrap_err_credit", 65'(err_credit), 65'd0);

    // Reset mid-stream with level 5 and 3 in flight
    for (int i = 0; i < 8; i++) step(0, 1, 0, '0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 65'(500 + i), 0);
    chk("mid_level", 65'(level), 65'd5);
    chk("mid_inflight", 65'(inflight), 65'd3);
    chk("mid_issue_ok", 65'(issue_ok), 65'd0);
    step(1, 1, 1, 65'd999, 1);
    chk("mid_rst_level", 65'(level), 65'd0);
    chk("mid_rst_inflight", 65'(inflight), 65'd0);
    chk("mid_rst_m_valid", 65'(m_valid), 65'd0);
    chk("mid_rst_issue_ok", 65'(issue_ok), 65'd1);
    chk("mid_rst_err_credit", 65'(err_credit), 65'd0);
    step(0, 0, 1, 65'd777, 0);
    chk("stray_err_credit", 65'(err_credit), 65'd1);
    chk("stray_level", 65'(level), 65'd1);
    chk("stray_data", m_data, 65'd777);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adder_result_buffer.md
ADDER_RESULT_BUFFER -- requirements
Module: adder_result_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 64, operand width of the upstream pipelined adder; result width is DATA_WIDTH+1.
REQ-002 Parameter DEPTH, default 8, FIFO entries; power of two, 2..64.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 issue  input  1  one-cycle pulse, high in the same cycle the adder's i_en is driven high.
REQ-006 o_en  input  1  adder result-valid strobe; no backpressure possible.
REQ-007 result  input  DATA_WIDTH+1  adder sum, carry in MSB, valid when o_en=1.
REQ-008 issue_ok  output  1  credit available; source may assert issue only when high.
REQ-009 m_valid  output  1  head entry valid.
REQ-010 m_data  output  DATA_WIDTH+1  head entry, first-word fall-through.
REQ-011 m_ready  input  1  consumer accepts head when m_valid&m_ready.
REQ-012 level  output  clog2(DEPTH+1)  current FIFO occupancy.
REQ-013 inflight  output  clog2(DEPTH+1)  issued operations not yet returned by o_en.
REQ-014 err_ovf  output  1  sticky: result arrived with no room, dropped.
REQ-015 err_credit  output  1  sticky: issue while issue_ok=0, or o_en with inflight=0.

Function
REQ-016 pop = m_valid & m_ready; push = o_en.
REQ-017 m_valid SHALL equal (level != 0); m_data SHALL equal storage at read pointer, combinationally, no added latency.
REQ-018 push accepted when level<DEPTH, or level==DEPTH with pop in the same cycle; otherwise result dropped, err_ovf set next cycle.
REQ-019 Accepted push written at write pointer; pointers wrap modulo DEPTH.
REQ-020 level next = level + accepted_push - pop; simultaneous push and pop leaves level unchanged.
REQ-021 Result reaches m_data one cycle after its o_en edge (write latency 1).
REQ-022 inflight next = inflight + issue - o_en, saturating at 0 and DEPTH; issue and o_en same cycle leaves it unchanged.
REQ-023 issue_ok SHALL be combinational: (inflight + level) < DEPTH.
REQ-024 issue while issue_ok=0 SHALL still count into inflight (subject to saturation) and set err_credit.
REQ-025 o_en while inflight=0 and issue=0 SHALL set err_credit; result still handled per REQ-018.
REQ-026 Under correct credit use (REQ-008), err_ovf SHALL never assert for any adder latency.
REQ-027 err_ovf and err_credit clear only on rst.
REQ-028 m_data when m_valid=0: don't-care, but SHALL NOT be X after reset (storage need not reset; output mux sees last written or zero).

Reset
REQ-029 rst=1 at a rising edge SHALL set level=0, inflight=0, pointers=0, err_ovf=0, err_credit=0; hence m_valid=0, issue_ok=1.
REQ-030 rst dominates: issue, o_en, m_ready in reset cycles are ignored.
REQ-031 rst asserted mid-operation discards all stored and in-flight entries; results returning after deassertion count as REQ-025 errors.

Verification
REQ-032 Single op: issue at cycle 0, o_en with result=65'h1_0000_0000_0000_0001 at cycle 4, m_ready=1 -> m_valid=1, m_data equal at cycle 5, level back to 0 at cycle 6, inflight 1 during cycles 1-4.
REQ-033 Credit fill, DEPTH=8, m_ready=0: issue every cycle while issue_ok -> exactly 8 issues, issue_ok=0 thereafter, level=8 after all returns, no errors.
REQ-034 Full with simultaneous push/pop: level=8, o_en=1 and m_ready=1 same cycle -> level stays 8, new entry at tail, old head dropped from front, err_ovf=0.
REQ-035 Overflow: level=8, m_ready=0, o_en=1 -> result dropped, level=8, err_ovf=1 next cycle, stays 1 until rst.
REQ-036 Wrap: 20 sequential values 0..19 pushed/popped with random m_ready -> output order 0..19, no loss, pointers wrap twice.
REQ-037 Reset mid-stream: level=5, inflight=3, rst one cycle -> level=0, inflight=0, m_valid=0, issue_ok=1; subsequent stray o_en sets err_credit.
